cache_ctrl_wb: RTL and testbench

Parametrised write-back, write-allocate cache controller FSM for the lab direct-mapped data cache. It sits between the CPU data port (Strobe/DRW/DReady) and the cache datapath/main memory, and drives the same select strobes as the current write-through controller. It adds a dirty bit, multi-word line bursts and a configurable memory latency. Victim write-back happens before a refill.

---
 rtl/cache_ctrl_wb_pkg.sv | 31 +++
 rtl/cache_ctrl_wb_mem_wait_ctr.sv | 26 ++
 rtl/cache_ctrl_wb.sv | 163 ++++++++++++++++
 tb/tb_cache_ctrl_wb.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_wb_pkg.sv
// Shared types and helpers for the write-back, write-allocate cache controller.
package cache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_WB_REQ,
      ST_WB_WAIT,
      ST_FILL_REQ,
      ST_FILL_WAIT
   } cache_state_t;

   localparam logic MRW_WRITE = 1'b1;
   localparam logic MRW_READ  = 1'b0;

   typedef struct packed {
      logic dready;
      logic w;
      logic dset;
      logic mstrobe;
      logic mrw;
      logic rsel;
      logic wsel;
      logic vicsel;
   } ctrl_out_t;

   function automatic int unsigned idx_width(input int unsigned words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/cache_ctrl_wb_mem_wait_ctr.sv
// Loadable down-counter for memory wait states; last flags the final wait cycle.
module mem_wait_ctr #(
   parameter int unsigned CTR_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CTR_W-1:0] value,
   output logic             last
);

   logic [CTR_W-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - CTR_W'(1);
      end
   end

   assign last = (count == CTR_W'(1));

endmodule

// File: rtl/cache_ctrl_wb.sv
// Write-back, write-allocate controller for the direct-mapped data cache.
// Optional statistics counters are enabled with `define CACHE_STATS_EN.
module cache_ctrl_wb
   import cache_pkg::*;
#(
   parameter int unsigned MEM_LAT    = 4,
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned CTR_W      = 8
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                Strobe,
   input  logic                                DRW,
   input  logic                                M,
   input  logic                                V,
   input  logic                                D,
   output logic                                DReady,
   output logic                                W,
   output logic                                DSet,
   output logic                                MStrobe,
   output logic                                MRW,
   output logic                                RSel,
   output logic                                WSel,
   output logic                                VicSel,
   output logic [idx_width(LINE_WORDS)-1:0]    WordIdx
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]                         HitCnt,
   output logic [31:0]                         MissCnt,
   output logic [31:0]                         WbCnt
`endif
);

   localparam int unsigned IDX_W = idx_width(LINE_WORDS);

   cache_state_t state, nxt;
   ctrl_out_t    ctl;
   logic         req_write;
   logic         idx_clr, idx_inc, ctr_load, ctr_last, last_word;

   mem_wait_ctr #(.CTR_W(CTR_W)) u_wait (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (ctr_load),
      .value   (CTR_W'(MEM_LAT)),
      .last    (ctr_last)
   );

   assign last_word = (WordIdx == IDX_W'(LINE_WORDS - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         req_write <= 1'b0;
         WordIdx   <= '0;
      end else begin
         state <= nxt;
         if (state == ST_IDLE && Strobe)
            req_write <= DRW;
         if (idx_clr)
            WordIdx <= '0;
         else if (idx_inc)
            WordIdx <= WordIdx + IDX_W'(1);
      end
   end

   always_comb begin
      nxt      = state;
      ctl      = '0;
      idx_clr  = 1'b0;
      idx_inc  = 1'b0;
      ctr_load = 1'b0;
      case (state)
         ST_IDLE: begin
            if (Strobe)
               nxt = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            if (M && V) begin
               ctl.dready = 1'b1;
               ctl.w      = req_write;
               ctl.dset   = req_write;
               nxt        = ST_IDLE;
            end else begin
               idx_clr = 1'b1;
               nxt     = (V && D) ? ST_WB_REQ : ST_FILL_REQ;
            end
         end
         ST_WB_REQ: begin
            ctl.mstrobe = 1'b1;
            ctl.mrw     = MRW_WRITE;
            ctl.wsel    = 1'b1;
            ctl.vicsel  = 1'b1;
            ctr_load    = 1'b1;
            nxt         = ST_WB_WAIT;
         end
         ST_WB_WAIT: begin
            ctl.mrw    = MRW_WRITE;
            ctl.wsel   = 1'b1;
            ctl.vicsel = 1'b1;
            if (ctr_last) begin
               if (last_word) begin
                  idx_clr = 1'b1;
                  nxt     = ST_FILL_REQ;
               end else begin
                  idx_inc = 1'b1;
                  nxt     = ST_WB_REQ;
               end
            end
         end
         ST_FILL_REQ: begin
            ctl.mstrobe = 1'b1;
            ctl.mrw     = MRW_READ;
            ctr_load    = 1'b1;
            nxt         = ST_FILL_WAIT;
         end
         ST_FILL_WAIT: begin
            if (ctr_last) begin
               ctl.w    = 1'b1;
               ctl.rsel = 1'b1;
               if (last_word) begin
                  idx_clr = 1'b1;
                  nxt     = ST_LOOKUP;
               end else begin
                  idx_inc = 1'b1;
                  nxt     = ST_FILL_REQ;
               end
            end
         end
         default: nxt = ST_IDLE;
      endcase
   end

   assign {DReady, W, DSet, MStrobe, MRW, RSel, WSel, VicSel} = ctl;

`ifdef CACHE_STATS_EN
   // retry marks the LOOKUP that follows a completed fill, so its hit is not counted.
   logic retry;
   logic hit_ev, miss_ev, wb_ev;

   assign hit_ev  = (state == ST_LOOKUP) && M && V && !retry;
   assign miss_ev = (state == ST_LOOKUP) && !(M && V);
   assign wb_ev   = (state == ST_LOOKUP) && (nxt == ST_WB_REQ);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retry   <= 1'b0;
         HitCnt  <= '0;
         MissCnt <= '0;
         WbCnt   <= '0;
      end else begin
         retry <= (state == ST_FILL_WAIT) && (nxt == ST_LOOKUP);
         if (hit_ev && HitCnt != '1)
            HitCnt <= HitCnt + 32'd1;
         if (miss_ev && MissCnt != '1)
            MissCnt <= MissCnt + 32'd1;
         if (wb_ev && WbCnt != '1)
            WbCnt <= WbCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Scoreboard bench for cache_ctrl_wb: expected per-cycle output traces are queued
// at request time and compared on the falling edge.
module tb_cache_ctrl_wb;

   localparam int unsigned LW  = 4;
   localparam int unsigned LAT = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       Strobe = 1'b0, DRW = 1'b0, M = 1'b0, V = 1'b0, D = 1'b0;
   logic       DReady, W, DSet, MStrobe, MRW, RSel, WSel, VicSel;
   logic [1:0] WordIdx;
`ifdef CACHE_STATS_EN
   logic [31:0] HitCnt, MissCnt, WbCnt;
`endif

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   typedef struct {
      string       tag;
      int unsigned k;
      logic [9:0]  v;
   } exp_t;

   exp_t exp_q[$];

   logic [9:0] out_vec;
   assign out_vec = {DReady, W, DSet, MStrobe, MRW, RSel, WSel, VicSel, WordIdx};

   cache_ctrl_wb #(.MEM_LAT(LAT), .LINE_WORDS(LW), .CTR_W(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .Strobe  (Strobe),
      .DRW     (DRW),
      .M       (M),
      .V       (V),
      .D       (D),
      .DReady  (DReady),
      .W       (W),
      .DSet    (DSet),
      .MStrobe (MStrobe),
      .MRW     (MRW),
      .RSel    (RSel),
      .WSel    (WSel),
      .VicSel  (VicSel),
      .WordIdx (WordIdx)
`ifdef CACHE_STATS_EN
      ,
      .HitCnt  (HitCnt),
      .MissCnt (MissCnt),
      .WbCnt   (WbCnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected {DReady,W,DSet,MStrobe,MRW,RSel,WSel,VicSel,WordIdx} in cycle k of a request.
   function automatic logic [9:0] exp_vec(input int unsigned k, input bit wr,
                                          input bit miss, input bit dirty);
      int unsigned n, last, rel, beat, ph;
      logic dr, w, ds, ms, mrw, rs, ws, vs;
      logic [1:0] idx;
      {dr, w, ds, ms, mrw, rs, ws, vs} = '0;
      idx  = '0;
      n    = LW * (LAT + 1);
      last = !miss ? 1 : (dirty ? 2 + 2 * n : 2 + n);
      if (k == last) begin
         dr = 1'b1;
         w  = wr;
         ds = wr;
      end else if (k >= 2) begin
         rel = k - 2;
         if (dirty && rel < n) begin
            beat = rel / (LAT + 1);
            ph   = rel % (LAT + 1);
            ms   = (ph == 0);
            mrw  = 1'b1;
            ws   = 1'b1;
            vs   = 1'b1;
            idx  = 2'(beat);
         end else begin
            if (dirty)
               rel = rel - n;
            beat = rel / (LAT + 1);
            ph   = rel % (LAT + 1);
            ms   = (ph == 0);
            w    = (ph == LAT);
            rs   = w;
            idx  = 2'(beat);
         end
      end
      return {dr, w, ds, ms, mrw, rs, ws, vs, idx};
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check($sformatf("%s_c%0d", e.tag, e.k), {22'b0, out_vec}, {22'b0, e.v});
      end
   end

   // Called just after a rising edge with the DUT idle; that cycle is cycle 0.
   task automatic run_req(input string name, input bit wr, input bit m, input bit v,
                          input bit d, input int unsigned abort_at);
      bit miss, dirty;
      int unsigned n, last;
      n     = LW * (LAT + 1);
      miss  = !(m && v);
      dirty = miss && v && d;
      last  = !miss ? 1 : (dirty ? 2 + 2 * n : 2 + n);
      Strobe = 1'b1;
      DRW    = wr;
      M      = m;
      V      = v;
      D      = d;
      for (int unsigned k = 0; k <= last; k++)
         exp_q.push_back('{name, k, exp_vec(k, wr, miss, dirty)});
      for (int unsigned k = 1; k <= last; k++) begin
         @(posedge clk);
         #1;
         if (k == abort_at) begin
            Strobe  = 1'b0;
            reset_n = 1'b0;
            exp_q.delete();
            #1;
            check({name, "_async_rst"}, {22'b0, out_vec}, 32'd0);
            @(posedge clk);
            #1;
            reset_n = 1'b1;
            @(negedge clk);
            check({name, "_idle_after_rst"}, {22'b0, out_vec}, 32'd0);
            @(posedge clk);
            #1;
            return;
         end
         if (k == last) begin
            Strobe = 1'b0;
            DRW    = 1'($urandom);
            M      = 1'b1;
            V      = 1'b1;
            D      = 1'($urandom);
         end else if (k == 1) begin
            Strobe = 1'($urandom);
            DRW    = 1'($urandom);
         end else begin
            Strobe = 1'($urandom);
            DRW    = 1'($urandom);
            M      = 1'($urandom);
            V      = 1'($urandom);
            D      = 1'($urandom);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      check("reset_outputs", {22'b0, out_vec}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      run_req("rd_hit",       1'b0, 1'b1, 1'b1, 1'b0, 0);
      run_req("wr_hit",       1'b1, 1'b1, 1'b1, 1'b1, 0);
      run_req("rd_miss_cln",  1'b0, 1'b0, 1'b1, 1'b0, 0);
      run_req("wr_miss_inv",  1'b1, 1'b0, 1'b0, 1'b1, 0);
      run_req("wr_miss_dty",  1'b1, 1'b0, 1'b1, 1'b1, 0);
      run_req("rd_miss_dty",  1'b0, 1'b0, 1'b1, 1'b1, 0);
      run_req("rst_mid",      1'b1, 1'b0, 1'b1, 1'b1, 9);
      run_req("hit_post_rst", 1'b0, 1'b1, 1'b1, 1'b0, 0);
      run_req("miss_post",    1'b1, 1'b1, 1'b0, 1'b0, 0);
      run_req("hit_last",     1'b1, 1'b1, 1'b1, 1'b0, 0);

`ifdef CACHE_STATS_EN
      check("hit_cnt",  HitCnt,  32'd2);
      check("miss_cnt", MissCnt, 32'd1);
      check("wb_cnt",   WbCnt,   32'd0);
`endif

      @(negedge clk);
      check("final_idle", {22'b0, out_vec}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
